// File: rtl/control_recirculador_pkg.sv
// Shared state encoding and lane helpers for the recirculator controller.
package control_recirculador_pkg;

   localparam int unsigned ST_W    = 3;
   localparam int unsigned N_LANES = 4;

   localparam logic [ST_W-1:0] ST_RESET  = 3'd0;
   localparam logic [ST_W-1:0] ST_INIT   = 3'd1;
   localparam logic [ST_W-1:0] ST_IDLE   = 3'd2;
   localparam logic [ST_W-1:0] ST_ACTIVE = 3'd3;
   localparam logic [ST_W-1:0] ST_ERROR  = 3'd4;

   function automatic logic todas_vacias(input logic [N_LANES-1:0] vacias);
      return &vacias;
   endfunction

endpackage

// File: rtl/control_recirculador_registro_umbrales.sv
// Almost-full / almost-empty threshold pair with load enable, async reset to
// defaults and an ordering check on the stored values.
module control_recirculador_registro_umbrales #(
   parameter int unsigned          UMBRAL_W     = 3,
   parameter logic [UMBRAL_W-1:0]  UMBRAL_A_RST = 3'd6,
   parameter logic [UMBRAL_W-1:0]  UMBRAL_B_RST = 3'd1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                carga,
   input  logic [UMBRAL_W-1:0] umbral_a_in,
   input  logic [UMBRAL_W-1:0] umbral_b_in,
   output logic [UMBRAL_W-1:0] umbral_a_out,
   output logic [UMBRAL_W-1:0] umbral_b_out,
   output logic                almacen_ok
);

   logic [UMBRAL_W-1:0] umbral_a_q, umbral_a_d;
   logic [UMBRAL_W-1:0] umbral_b_q, umbral_b_d;

   always_comb begin
      umbral_a_d = umbral_a_q;
      umbral_b_d = umbral_b_q;
      if (carga) begin
         umbral_a_d = umbral_a_in;
         umbral_b_d = umbral_b_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         umbral_a_q <= UMBRAL_A_RST;
         umbral_b_q <= UMBRAL_B_RST;
      end else begin
         umbral_a_q <= umbral_a_d;
         umbral_b_q <= umbral_b_d;
      end
   end

   assign umbral_a_out = umbral_a_q;
   assign umbral_b_out = umbral_b_q;
   assign almacen_ok   = (umbral_b_q < umbral_a_q);

endmodule

// File: rtl/control_recirculador.sv
// Moore sequencer for the 4-lane recirculator: gates 'active', owns the FIFO
// thresholds and latches per-lane error history.
module control_recirculador
   import control_recirculador_pkg::*;
#(
   parameter int unsigned          UMBRAL_W     = 3,
   parameter logic [UMBRAL_W-1:0]  UMBRAL_A_RST = 3'd6,
   parameter logic [UMBRAL_W-1:0]  UMBRAL_B_RST = 3'd1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [UMBRAL_W-1:0] umbral_a_in,
   input  logic [UMBRAL_W-1:0] umbral_b_in,
   input  logic [3:0]          fifo_empty,
   input  logic [3:0]          fifo_error,
   output logic                active,
   output logic                idle,
   output logic                error,
   output logic [3:0]          error_lane,
   output logic                config_ok,
   output logic [UMBRAL_W-1:0] umbral_a_out,
   output logic [UMBRAL_W-1:0] umbral_b_out,
   output logic [2:0]          estado
);

   logic [ST_W-1:0] estado_q, estado_d;
   logic [3:0]      error_lane_q, error_lane_d;
   logic            carga;
   logic            umbral_valido;
   logic            almacen_ok;
   logic            hay_error;

   assign umbral_valido = (umbral_b_in < umbral_a_in);
   assign hay_error     = |fifo_error;

   always_comb begin
      estado_d     = estado_q;
      carga        = 1'b0;
      error_lane_d = error_lane_q | fifo_error;
      case (estado_q)
         ST_RESET:  estado_d = ST_INIT;
         ST_INIT: begin
            // Invalid pairs are never stored, so the registers always hold a legal config.
            carga = umbral_valido;
            if (hay_error)                   estado_d = ST_ERROR;
            else if (!init && umbral_valido) estado_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (hay_error)                      estado_d = ST_ERROR;
            else if (init)                      estado_d = ST_INIT;
            else if (!todas_vacias(fifo_empty)) estado_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (hay_error)                     estado_d = ST_ERROR;
            else if (init)                     estado_d = ST_INIT;
            else if (todas_vacias(fifo_empty)) estado_d = ST_IDLE;
         end
         ST_ERROR:  estado_d = ST_ERROR;
         default:   estado_d = ST_ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q     <= ST_RESET;
         error_lane_q <= 4'b0000;
      end else begin
         estado_q     <= estado_d;
         error_lane_q <= error_lane_d;
      end
   end

   control_recirculador_registro_umbrales #(
      .UMBRAL_W     (UMBRAL_W),
      .UMBRAL_A_RST (UMBRAL_A_RST),
      .UMBRAL_B_RST (UMBRAL_B_RST)
   ) u_registro_umbrales (
      .clk          (clk),
      .reset        (reset),
      .carga        (carga),
      .umbral_a_in  (umbral_a_in),
      .umbral_b_in  (umbral_b_in),
      .umbral_a_out (umbral_a_out),
      .umbral_b_out (umbral_b_out),
      .almacen_ok   (almacen_ok)
   );

   always_comb begin
      active     = (estado_q == ST_ACTIVE);
      idle       = (estado_q == ST_IDLE);
      error      = (estado_q == ST_ERROR);
      error_lane = error_lane_q;
      estado     = estado_q;
      // While configuring, report on the pair being offered rather than the stored one.
      config_ok  = (estado_q == ST_INIT) ? umbral_valido : almacen_ok;
   end

endmodule
